ex_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage, fed by the ID/EX register (R1/R2 operands, decoded op).

---
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit for the EX stage; owns HI/LO and stalls the front end.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divides stay iterative.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opb;
    logic [31:0] r_a;
    logic [63:0] r_acc;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;

    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_accept;
    logic        w_mt_ok;
    logic [32:0] w_madd;
    logic [32:0] w_rem_sh;
    logic        w_sub_ok;
    logic [31:0] w_diff;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign w_sign_a = ~i_op[0] & i_a[31];
    assign w_sign_b = ~i_op[0] & i_b[31];
    assign w_abs_a  = w_sign_a ? -i_a : i_a;
    assign w_abs_b  = w_sign_b ? -i_b : i_b;
    assign w_accept = (r_state == ST_IDLE) & i_start & ~i_flush;
    assign w_mt_ok  = (r_state == ST_IDLE) | (r_state == ST_DONE);

    // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign w_madd   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_rem_sh = {r_acc[63:32], r_acc[31]};
    assign w_sub_ok = w_rem_sh >= {1'b0, r_opb};
    assign w_diff   = w_rem_sh[31:0] - r_opb;
    assign w_step   = r_is_div ?
                      (w_sub_ok ? {w_diff, r_acc[30:0], 1'b1} : {w_rem_sh[31:0], r_acc[30:0], 1'b0})
                      : {w_madd, r_acc[31:1]};
    assign w_prod   = r_neg_q ? -w_step : w_step;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = r_neg_r ? -w_step[63:32] : w_step[63:32];
                w_res_lo = r_neg_q ? -w_step[31:0] : w_step[31:0];
            end
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = i_op[0] ? ({32'd0, i_a} * {32'd0, i_b})
                                 : ($signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b}));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opb    <= 32'd0;
            r_a      <= 32'd0;
            r_acc    <= 64'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            if (w_mt_ok && i_hi_we) r_hi <= i_wdata;
            if (w_mt_ok && i_lo_we) r_lo <= i_wdata;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_BUSY;
                        r_cnt    <= 5'd0;
                        r_is_div <= i_op[1];
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_a      <= i_a;
                        r_b_zero <= (i_b == 32'd0);
                        r_opb    <= i_op[1] ? w_abs_b : w_abs_a;
                        r_acc    <= {32'd0, (i_op[1] ? w_abs_a : w_abs_b)};
`ifdef MULDIV_FAST_MUL_EN
                        // Fast product wins over a same-cycle MTHI/MTLO
                        if (!i_op[1]) begin
                            r_hi    <= w_fast_prod[63:32];
                            r_lo    <= w_fast_prod[31:0];
                            r_state <= ST_DONE;
                        end
`endif
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_hi    <= w_res_hi;
                            r_lo    <= w_res_lo;
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = (r_state == ST_BUSY);
    assign o_done  = (r_state == ST_DONE);
    assign o_stall = w_accept | o_busy;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized bench for ex_muldiv: arithmetic/timing reference model plus directed literal cases.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ExpMulStall = 1;
`else
    localparam int ExpMulStall = 33;
`endif

    ex_muldiv dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_flush (flush),
        .i_hi_we (hi_we),
        .i_lo_we (lo_we),
        .i_wdata (wdata),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_busy  (busy),
        .o_done  (done),
        .o_stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] fop, input logic [31:0] fa,
                                               input logic [31:0] fb);
        longint p;
        int     sa;
        int     sb;
        int     q;
        int     r;
        case (fop)
            2'd0: begin
                p = longint'($signed(fa)) * longint'($signed(fb));
                return p;
            end
            2'd1: return {32'd0, fa} * {32'd0, fb};
            2'd2: begin
                if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
                if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(fa);
                sb = $signed(fb);
                q  = sa / sb;
                r  = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
                return {fa % fb, fa / fb};
            end
        endcase
    endfunction

    // Reference model: m_left = busy cycles still to run, m_done = completion cycle
    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [63:0] m_pend = 0;

    initial begin : model
        logic [63:0] res;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_left = 0;
                m_done = 0;
                m_hi   = 0;
                m_lo   = 0;
            end else begin
                bit was_done;
                was_done = m_done;
                m_done   = 0;
                if (m_left == 0) begin
                    if (hi_we) m_hi = wdata;
                    if (lo_we) m_lo = wdata;
                end
                if (flush) begin
                    m_left = 0;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = m_pend;
                        m_done = 1;
                    end
                end else if (!was_done && start) begin
                    res = ref_result(op, a, b);
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[1]) begin
                        {m_hi, m_lo} = res;
                        m_done = 1;
                    end else begin
                        m_pend = res;
                        m_left = 32;
                    end
`else
                    m_pend = res;
                    m_left = 32;
`endif
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("hi", hi, m_hi);
                chk("lo", lo, m_lo);
                chk("busy", busy, m_left > 0);
                chk("done", done, m_done);
                chk("stall", stall, (m_left > 0) || (!m_done && start && !flush));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait for the op to leave the stall region; start is held through DONE and dropped after
    task automatic finish_op(output int nstall, output int ndone);
        bit fin;
        fin    = 0;
        nstall = 0;
        ndone  = 0;
        for (int k = 0; k < 80 && !fin; k++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (done) ndone++;
            if (!stall) fin = 1;
            else tick();
        end
        chk("op_timeout", fin, 1'b1);
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (done) ndone++;
        end
        tick();
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int nstall, output int ndone);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        finish_op(nstall, ndone);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom % 16);
            4:       return -32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ns;
        int nd;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        @(posedge clk);
        cmp_en = 1;
        tick();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_stall", stall, 1'b0);
        tick();

        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, ns, nd);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        chk("multu_stall_cycles", ns, ExpMulStall);
        chk("multu_done_pulses", nd, 1);

        run_op(2'd0, -32'd3, 32'd5, ns, nd);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        run_op(2'd2, -32'd7, 32'd2, ns, nd);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_stall_cycles", ns, 33);

        run_op(2'd3, 32'd7, 32'd0, ns, nd);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd7);

        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, ns, nd);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_known", $isunknown({hi, lo}), 1'b0);

        // Flush at busy step 10
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        repeat (10) tick();
        flush = 1'b1;
        start = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'h8000_0000);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("flush_no_done", nd, 0);
        tick();

        // Reset mid-operation
        start = 1'b1;
        op    = 2'd0;
        a     = 32'd12345;
        b     = 32'd678;
        repeat (11) tick();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_stall", stall, 1'b0);

        // MTHI in idle, MTLO during busy is dropped
        hi_we = 1'b1;
        wdata = 32'h1234;
        tick();
        hi_we = 1'b0;
        chk("mthi", hi, 32'h1234);
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd20;
        b     = 32'd6;
        tick();
        lo_we = 1'b1;
        wdata = 32'h5555;
        repeat (4) tick();
        chk("mtlo_busy_hi", hi, 32'h1234);
        chk("mtlo_busy_lo", lo, 32'd0);
        chk("mtlo_busy", busy, 1'b1);
        lo_we = 1'b0;
        finish_op(ns, nd);
        chk("held_start_done", nd, 1);
        chk("held_start_lo", lo, 32'd3);
        chk("held_start_hi", hi, 32'd2);

        // Random phase, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom % 4) != 0;
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
            flush = ($urandom % 40) == 0;
            hi_we = ($urandom % 12) == 0;
            lo_we = ($urandom % 12) == 0;
            wdata = $urandom;
            rst   = ($urandom % 900) == 0;
            tick();
        end
        start = 1'b0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        rst   = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
